tx_gearbox_6432: RTL

TX_GEARBOX_6432 -- requirements
Module: tx_gearbox_6432

---
 rtl/tx_gearbox_6432_if.sv | 31 +++
 rtl/tx_gearbox_6432.sv | 101 ++++++++++
 2 files changed

// File: rtl/tx_gearbox_6432_if.sv
// Block/word handshake bundle between the 64b/66b encoder, the TX gearbox and the PMA.
// The slave side is the gearbox; the master side drives blocks in and takes words out.
interface tx_gearbox_6432_if;
    localparam int unsigned BLK_W  = 66;
    localparam int unsigned WORD_W = 32;

    logic [0:BLK_W-1]  i_txd;
    logic              i_tx_valid;
    logic              o_tx_ready;
    logic [0:WORD_W-1] o_txd;
    logic              o_tx_valid;
    logic              o_underrun;

    modport slave (
        input  i_txd,
        input  i_tx_valid,
        output o_tx_ready,
        output o_txd,
        output o_tx_valid,
        output o_underrun
    );

    modport master (
        output i_txd,
        output i_tx_valid,
        input  o_tx_ready,
        input  o_txd,
        input  o_tx_valid,
        input  o_underrun
    );
endinterface

// File: rtl/tx_gearbox_6432.sv
// 66b-to-32b TX gearbox with optional x^58+x^39+1 payload scrambler.
// Accepts 16 blocks per 33-cycle period and emits one 32-bit word per cycle in serial bit order.
module tx_gearbox_6432 #(
    parameter bit SCRAMBLER_BYPASS = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    tx_gearbox_6432_if.slave   tx
);
    localparam int unsigned BLK_W    = 66;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned BUF_W    = 98;
    localparam int unsigned SCR_W    = 58;
    localparam int unsigned SEQ_W    = 6;
    localparam int unsigned FILL_W   = 7;
    localparam int unsigned SEQ_LAST = 32;

    localparam logic [0:BLK_W-1] IDLE_BLK = {2'b10, 8'h1e, 56'h0};

    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [0:BUF_W-1]  buf_q, buf_d;
    logic [SCR_W-1:0]  scr_q, scr_d;
    logic [0:WORD_W-1] txd_q, txd_d;
    logic              tx_valid_q, tx_valid_d;
    logic              underrun_q, underrun_d;

    logic              accept_c;
    logic [0:BLK_W-1]  blk_c;
    logic [0:BLK_W-1]  blk_scr_c;
    logic [SCR_W-1:0]  scr_c;
    logic              scr_bit_c;
    logic [FILL_W-1:0] fill_rem_c;
    logic [0:BUF_W-1]  buf_rem_c;

    // Accept slots are the even sequence values except the final one of the period.
    assign accept_c      = !i_reset && !seq_q[0] && (seq_q != SEQ_W'(SEQ_LAST));
    assign tx.o_tx_ready = accept_c;
    assign tx.o_txd      = txd_q;
    assign tx.o_tx_valid = tx_valid_q;
    assign tx.o_underrun = underrun_q;

    // Idle substitution and bit-serial self-synchronous scrambling of the payload.
    always_comb begin
        blk_c     = tx.i_tx_valid ? tx.i_txd : IDLE_BLK;
        blk_scr_c = blk_c;
        scr_c     = scr_q;
        scr_bit_c = 1'b0;
        if (!SCRAMBLER_BYPASS) begin
            for (int i = 2; i < BLK_W; i++) begin
                scr_bit_c    = blk_c[i] ^ scr_c[38] ^ scr_c[57];
                blk_scr_c[i] = scr_bit_c;
                scr_c        = {scr_c[SCR_W-2:0], scr_bit_c};
            end
        end
        scr_d = accept_c ? scr_c : scr_q;
    end

    // Drain one word when available, then append the accepted block behind what remains.
    always_comb begin
        seq_d      = (seq_q == SEQ_W'(SEQ_LAST)) ? '0 : seq_q + SEQ_W'(1);
        txd_d      = txd_q;
        tx_valid_d = 1'b0;
        fill_rem_c = fill_q;
        buf_rem_c  = buf_q;
        underrun_d = 1'b0;
        if (fill_q >= FILL_W'(WORD_W)) begin
            txd_d      = buf_q[0:WORD_W-1];
            tx_valid_d = 1'b1;
            fill_rem_c = fill_q - FILL_W'(WORD_W);
            buf_rem_c  = buf_q << WORD_W;
        end
        fill_d = fill_rem_c;
        buf_d  = buf_rem_c;
        if (accept_c) begin
            buf_d      = buf_rem_c | ({blk_scr_c, {(BUF_W-BLK_W){1'b0}}} >> fill_rem_c);
            fill_d     = fill_rem_c + FILL_W'(BLK_W);
            underrun_d = !tx.i_tx_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            seq_q      <= '0;
            fill_q     <= '0;
            buf_q      <= '0;
            scr_q      <= '1;
            txd_q      <= '0;
            tx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            seq_q      <= seq_d;
            fill_q     <= fill_d;
            buf_q      <= buf_d;
            scr_q      <= scr_d;
            txd_q      <= txd_d;
            tx_valid_q <= tx_valid_d;
            underrun_q <= underrun_d;
        end
    end
endmodule
